// File: rtl/video_pkg.sv
// Shared video-path types: line-delay FSM states, error bit indices and
// default 1080p active timing.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } ld_state_t;

    localparam int ERR_SYNC = 0;
    localparam int ERR_OVF  = 1;
    localparam int ERR_UDF  = 2;

    localparam int H_ACTIVE_1080P = 1920;
    localparam int V_ACTIVE_1080P = 1080;

endpackage

// File: rtl/pix_align_pipe.sv
// Two-stage delay line for {vld, first, cur}, so the current pixel lines up
// with the FIFO read data of the line above.
module pix_align_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic              first_i,
    input  logic [DATA_W-1:0] cur_i,
    output logic              vld_o,
    output logic              first_o,
    output logic [DATA_W-1:0] cur_o
);

    localparam int STAGES = 2;

    logic [STAGES-1:0][DATA_W+1:0] stg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q <= '0;
        end else begin
            stg_q[0] <= {vld_i, first_i, cur_i};
            for (int i = 1; i < STAGES; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign vld_o   = stg_q[STAGES-1][DATA_W+1];
    assign first_o = stg_q[STAGES-1][DATA_W];
    assign cur_o   = stg_q[STAGES-1][DATA_W-1:0];

endmodule

// File: rtl/line_delay_ctrl.sv
// One-line delay controller in front of fifo_shift; emits (current, above) pixel
// pairs. Build option LINE_DELAY_REPLICATE_EN replicates the top border in FILL.
module line_delay_ctrl
    import video_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = H_ACTIVE_1080P,
    parameter int V_ACTIVE = V_ACTIVE_1080P,
    parameter int DEPTH_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic              in_sof,
    input  logic              in_eol,
    input  logic [DATA_W-1:0] in_data,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_wr_full,
    input  logic              fifo_rd_empty,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_cur,
    output logic [DATA_W-1:0] out_prev,
    output logic              out_first,
    output logic [2:0]        err
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    ld_state_t         state_q, state_d;
    logic [XW-1:0]     x_q, x_d, x_base;
    logic [YW-1:0]     y_q, y_d, y_base;
    logic [DEPTH_W:0]  occ_q, occ_d;
    logic [2:0]        err_q, err_d;
    logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_dly_q;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              accept, sync_err, pix_vld, pix_first;
    logic [DATA_W-1:0] pix_cur;
    logic              pv, pf;
    logic [DATA_W-1:0] pc, prev_d;
    logic              out_vld_q, out_first_q;
    logic [DATA_W-1:0] out_cur_q, out_prev_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        pix_vld   = 1'b0;
        pix_first = 1'b0;
        sync_err  = 1'b0;
        x_base    = (state_q == IDLE) ? '0 : x_q;
        y_base    = (state_q == IDLE) ? '0 : y_q;
        accept    = in_vld && ((state_q == IDLE && in_sof) || state_q == FILL || state_q == RUN);

        if (accept) begin
            sync_err = (in_eol != (x_base == X_LAST)) || (in_sof && state_q != IDLE);
            if (sync_err) begin
                err_d[ERR_SYNC] = 1'b1;
                state_d         = DRAIN;
            end else begin
                pix_vld   = 1'b1;
                pix_first = (state_q != RUN);
                if (fifo_wr_full) begin
                    err_d[ERR_OVF] = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_data_d = in_data;
                end
                if (state_q == RUN) begin
                    if (fifo_rd_empty) err_d[ERR_UDF] = 1'b1;
                    else               rd_en_d        = 1'b1;
                end
                if (in_eol) begin
                    x_d     = '0;
                    y_d     = y_base + 1'b1;
                    state_d = (y_base == Y_LAST) ? DRAIN : RUN;
                end else begin
                    x_d = x_base + 1'b1;
                    y_d = y_base;
                    if (state_q == IDLE) state_d = FILL;
                end
            end
        end

        // occ_q counts issued ops, so the drain stops exactly at the last entry
        // even though fifo_rd_empty lags our registered read by a cycle.
        if (state_q == DRAIN) begin
            x_d     = '0;
            y_d     = '0;
            rd_en_d = (occ_q != '0) && !fifo_rd_empty;
            if (fifo_rd_empty && !rd_en_q && !wr_en_q) state_d = IDLE;
        end

        occ_d = occ_q + (DEPTH_W+1)'(wr_en_d) - (DEPTH_W+1)'(rd_en_d);
    end

    assign pix_cur = pix_vld ? in_data : '0;

    pix_align_pipe #(.DATA_W(DATA_W)) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_i   (pix_vld),
        .first_i (pix_first),
        .cur_i   (pix_cur),
        .vld_o   (pv),
        .first_o (pf),
        .cur_o   (pc)
    );

    always_comb begin
        prev_d = '0;
        if (pv) begin
            if (rd_dly_q) begin
                prev_d = fifo_rd_data;
            end else begin
`ifdef LINE_DELAY_REPLICATE_EN
                prev_d = pf ? pc : '0;
`else
                prev_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            occ_q       <= '0;
            err_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_dly_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_first_q <= 1'b0;
            out_cur_q   <= '0;
            out_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            occ_q       <= occ_d;
            err_q       <= err_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_dly_q    <= rd_en_q;
            out_vld_q   <= pv;
            out_first_q <= pv & pf;
            out_cur_q   <= pc;
            out_prev_q  <= prev_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign fifo_rd_en   = rd_en_q;
    assign out_vld      = out_vld_q;
    assign out_first    = out_first_q;
    assign out_cur      = out_cur_q;
    assign out_prev     = out_prev_q;
    assign err          = err_q;

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Directed bench for line_delay_ctrl with a 1-cycle-latency FIFO model;
// 16x4 frames, expected pairs computed from the pixel pattern base+x+16*y.
module tb_line_delay_ctrl;

    localparam int DW = 8;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int DEPTH_W = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld, in_sof, in_eol;
    logic [DW-1:0] in_data;
    logic          fifo_wr_en, fifo_rd_en, fifo_wr_full, fifo_rd_empty;
    logic [DW-1:0] fifo_wr_data, fifo_rd_data;
    logic          out_vld, out_first;
    logic [DW-1:0] out_cur, out_prev;
    logic [2:0]    err;

    always #5 clk = ~clk;

    line_delay_ctrl #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .DEPTH_W(DEPTH_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_vld        (in_vld),
        .in_sof        (in_sof),
        .in_eol        (in_eol),
        .in_data       (in_data),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_wr_full  (fifo_wr_full),
        .fifo_rd_empty (fifo_rd_empty),
        .out_vld       (out_vld),
        .out_cur       (out_cur),
        .out_prev      (out_prev),
        .out_first     (out_first),
        .err           (err)
    );

    // Behavioural fifo_shift: 2048 x 8, registered read data, reset with ~rst_n.
    logic [DW-1:0] mem [0:2047];
    logic [10:0]   wp, rp;
    logic [11:0]   lvl;
    logic          do_wr, do_rd;
    assign fifo_rd_empty = (lvl == 12'd0);
    assign fifo_wr_full  = (lvl == 12'd2048);
    assign do_wr = fifo_wr_en && !fifo_wr_full;
    assign do_rd = fifo_rd_en && !fifo_rd_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; lvl <= '0; fifo_rd_data <= '0;
        end else begin
            if (do_wr) begin mem[wp] <= fifo_wr_data; wp <= wp + 11'd1; end
            if (do_rd) begin fifo_rd_data <= mem[rp]; rp <= rp + 11'd1; end
            lvl <= lvl + 12'(do_wr) - 12'(do_rd);
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int rd_cnt = 0;

    bit            ev_q [3];
    bit            ef_q [3];
    logic [DW-1:0] ec_q [3];
    logic [DW-1:0] ep_q [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 3; i++) begin
            ev_q[i] = 0; ef_q[i] = 0; ec_q[i] = '0; ep_q[i] = '0;
        end
    endtask

    // One clock: check the pair expected from 3 steps ago, then drive new inputs.
    task automatic step(input bit v, input bit s, input bit e, input logic [DW-1:0] d,
                        input bit ev, input logic [DW-1:0] ec, input logic [DW-1:0] ep,
                        input bit ef);
        @(negedge clk);
        chk("out_vld", out_vld, ev_q[2]);
        if (ev_q[2]) begin
            chk("out_cur", out_cur, ec_q[2]);
            chk("out_prev", out_prev, ep_q[2]);
            chk("out_first", out_first, ef_q[2]);
        end
        if (fifo_rd_en) rd_cnt++;
        for (int i = 2; i > 0; i--) begin
            ev_q[i] = ev_q[i-1]; ef_q[i] = ef_q[i-1];
            ec_q[i] = ec_q[i-1]; ep_q[i] = ep_q[i-1];
        end
        ev_q[0] = ev; ef_q[0] = ef; ec_q[0] = ec; ep_q[0] = ep;
        in_vld = v; in_sof = s; in_eol = e; in_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'hA5, 0, '0, '0, 0);
    endtask

    function automatic logic [DW-1:0] pix(input logic [DW-1:0] base, input int x, input int y);
        return base + DW'(x + 16 * y);
    endfunction

    task automatic good_pix(input logic [DW-1:0] base, input int x, input int y);
        logic [DW-1:0] d, ep;
        d = pix(base, x, y);
`ifdef LINE_DELAY_REPLICATE_EN
        ep = (y == 0) ? d : d - 8'd16;
`else
        ep = (y == 0) ? 8'd0 : d - 8'd16;
`endif
        step(1, (x == 0 && y == 0), (x == H - 1), d, 1, d, ep, (y == 0));
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit gaps);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (gaps && $urandom_range(0, 1) == 1) idle(1);
                good_pix(base, x, y);
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clr_exp();
        rst_n = 0; in_vld = 0; in_sof = 0; in_eol = 0;
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_cur", out_cur, 0);
        chk("rst_out_prev", out_prev, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        in_vld = 0; in_sof = 0; in_eol = 0; in_data = '0;
        clr_exp();
        repeat (3) @(negedge clk);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_out_cur", out_cur, 0);
        chk("reset_out_prev", out_prev, 0);
        chk("reset_out_first", out_first, 0);
        chk("reset_wr_en", fifo_wr_en, 0);
        chk("reset_wr_data", fifo_wr_data, 0);
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        rst_n = 1;
        idle(2);

        // IDLE ignores pixels without sof
        repeat (3) step(1, 0, 0, 8'h11, 0, '0, '0, 0);
        idle(3);
        chk("idle_no_write", lvl, 0);

        // Back-to-back frame, then drain of exactly one line
        send_frame(8'h00, 0);
        idle(1);
        rd_cnt = 0;
        idle(22);
        chk("drain_rd_cnt", rd_cnt, 16);
        chk("drain_empty", fifo_rd_empty, 1);
        chk("frame1_err", err, 0);

        // Random 50% gaps in in_vld
        send_frame(8'h40, 1);
        idle(22);
        chk("gaps_err", err, 0);
        chk("gaps_empty", fifo_rd_empty, 1);

        // Early eol at x=10 on line 2
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < H; x++) good_pix(8'h80, x, y);
        for (int x = 0; x < 10; x++) good_pix(8'h80, x, 2);
        step(1, 0, 1, pix(8'h80, 10, 2), 0, '0, '0, 0);
        rd_cnt = 0;
        for (int x = 11; x < H; x++) step(1, 0, (x == H - 1), pix(8'h80, x, 2), 0, '0, '0, 0);
        idle(22);
        chk("eol_err_sync", err, 3'b001);
        chk("eol_drain_rd", rd_cnt, 16);
        chk("eol_empty", fifo_rd_empty, 1);
        send_frame(8'hC0, 0);
        idle(22);
        chk("eol_err_sticky", err, 3'b001);

        // Reset mid line 2 clears everything including err
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < H; x++) good_pix(8'h10, x, y);
        for (int x = 0; x < 5; x++) good_pix(8'h10, x, 2);
        pulse_reset();
        idle(3);
        chk("after_rst_err", err, 0);
        chk("after_rst_lvl", lvl, 0);
        send_frame(8'h20, 0);
        idle(22);
        chk("post_rst_frame_err", err, 0);

        // sof in the middle of line 1
        for (int x = 0; x < H; x++) good_pix(8'h30, x, 0);
        for (int x = 0; x < 6; x++) good_pix(8'h30, x, 1);
        step(1, 1, 0, pix(8'h30, 6, 1), 0, '0, '0, 0);
        rd_cnt = 0;
        idle(25);
        chk("sof_err_sync", err, 3'b001);
        chk("sof_drain_rd", rd_cnt, 16);
        chk("sof_empty", fifo_rd_empty, 1);
        send_frame(8'h55, 1);
        idle(22);
        chk("sof_next_err", err, 3'b001);
        chk("sof_next_empty", fifo_rd_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
